// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// pipeline stage indices and the default mul/div watchdog limit.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    // Stage indices used to address the per-stage stall/flush vectors.
    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

    localparam int MD_MAX_CYC_DEF = 64;

    // Holding a stage means every earlier stage must hold too, so build
    // the stall mask from IF up to and including the given stage.
    function automatic logic [4:0] stall_upto(input int unsigned stg);
        logic [4:0] mask;
        mask = 5'b00000;
        for (int unsigned i = 0; i < 5; i++) begin
            if (i <= stg) begin
                mask[i] = 1'b1;
            end else begin
                mask[i] = 1'b0;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: hazard sources from the pipeline, stall/flush
// enables and mul/div control back to it, plus the perf counter outputs.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_is_md;
    logic             md_start;
    logic             md_abort;
    logic             md_done;
    logic             mem_req;
    logic             mem_ready;
    logic             ex_redirect;
    logic             trap_req;
    logic             trap_ack;
    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             stall_mem;
    logic             flush_id;
    logic             flush_ex;
    logic             flush_mem;
    logic             flush_wb;
    logic [CNT_W-1:0] perf_ld_bubbles;
    logic [CNT_W-1:0] perf_mem_wait;
    logic [CNT_W-1:0] perf_md_cyc;
    logic [CNT_W-1:0] perf_redirects;

    // Pipeline side: reports hazards, obeys stall/flush.
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_is_md, md_done, mem_req, mem_ready, ex_redirect, trap_req,
        input  md_start, md_abort, trap_ack, stall_if, stall_id, stall_ex,
               stall_mem, flush_id, flush_ex, flush_mem, flush_wb,
               perf_ld_bubbles, perf_mem_wait, perf_md_cyc, perf_redirects
    );

    // Controller side.
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_is_md, md_done, mem_req, mem_ready, ex_redirect, trap_req,
        output md_start, md_abort, trap_ack, stall_if, stall_id, stall_ex,
               stall_mem, flush_id, flush_ex, flush_mem, flush_wb,
               perf_ld_bubbles, perf_mem_wait, perf_md_cyc, perf_redirects
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_perf_counters.sv
// Saturating hazard performance counters (load-use bubbles, memory wait
// cycles, mul/div wait cycles, honoured redirects). Only built when
// HAZARD_PERF_EN is defined.
`ifdef HAZARD_PERF_EN
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ld_bubble,
    input  logic             i_mem_wait,
    input  logic             i_md_cyc,
    input  logic             i_redirect,
    output logic [CNT_W-1:0] o_ld_bubbles,
    output logic [CNT_W-1:0] o_mem_wait,
    output logic [CNT_W-1:0] o_md_cyc,
    output logic [CNT_W-1:0] o_redirects
);
    logic [3:0]       w_inc;
    logic [CNT_W-1:0] r_cnt [4];

    assign w_inc = {i_redirect, i_md_cyc, i_mem_wait, i_ld_bubble};

    // Count each event, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_inc[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
            end
        end
    end

    assign o_ld_bubbles = r_cnt[0];
    assign o_mem_wait   = r_cnt[1];
    assign o_md_cyc     = r_cnt[2];
    assign o_redirects  = r_cnt[3];
endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline. Resolves, in
// priority order, memory wait > trap > mul/div > redirect > load-use.
// Optional perf counters are enabled with the HAZARD_PERF_EN macro.
module pipeline_hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MD_MAX_CYC = MD_MAX_CYC_DEF
) (
    input logic                   clk,
    input logic                   rst_n,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WD_W = (MD_MAX_CYC > 1) ? $clog2(MD_MAX_CYC) : 1;

    hz_state_e       r_state;
    hz_state_e       w_state_nxt;
    logic [WD_W-1:0] r_wd;
    logic [4:0]      w_stall;
    logic [4:0]      w_flush;
    logic            w_md_start;
    logic            w_md_abort;
    logic            w_trap_ack;
    logic            w_ld_bubble;
    logic            w_redir_take;
    logic            w_md_hold;
    logic            w_mem_wait;
    logic            w_load_use;
    logic            w_wd_expire;

    assign w_mem_wait  = hz.mem_req & ~hz.mem_ready;
    assign w_load_use  = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                         ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                          (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));
    assign w_wd_expire = (r_wd == WD_W'(MD_MAX_CYC - 1));

    // Priority resolution of hazards into stall/flush enables and next state.
    always_comb begin
        w_state_nxt  = r_state;
        w_stall      = 5'b00000;
        w_flush      = 5'b00000;
        w_md_start   = 1'b0;
        w_md_abort   = 1'b0;
        w_trap_ack   = 1'b0;
        w_ld_bubble  = 1'b0;
        w_redir_take = 1'b0;
        w_md_hold    = 1'b0;
        if (!rst_n) begin
            // Outputs forced quiet while reset is asserted.
            w_state_nxt = RUN;
        end else if (w_mem_wait) begin
            w_stall          = stall_upto(STG_MEM);
            w_flush[STG_WB]  = 1'b1;
            // A mul/div in flight keeps waiting; otherwise track the memory wait.
            if (r_state == MD_WAIT) begin
                w_state_nxt = MD_WAIT;
            end else begin
                w_state_nxt = MEM_WAIT;
            end
        end else if (hz.trap_req) begin
            w_flush[STG_ID]  = 1'b1;
            w_flush[STG_EX]  = 1'b1;
            w_flush[STG_MEM] = 1'b1;
            w_trap_ack       = 1'b1;
            w_md_abort       = (r_state == MD_WAIT);
            w_state_nxt      = RUN;
        end else begin
            w_state_nxt = RUN;
            if (r_state == MD_WAIT) begin
                if (hz.md_done) begin
                    w_md_hold = 1'b0;
                end else if (w_wd_expire) begin
                    w_md_abort = 1'b1;
                end else begin
                    w_md_hold   = 1'b1;
                    w_state_nxt = MD_WAIT;
                end
            end else if (hz.ex_is_md) begin
                // Start cycle already holds the mul/div in ID/EX.
                w_md_start  = 1'b1;
                w_md_hold   = 1'b1;
                w_state_nxt = MD_WAIT;
            end else begin
                w_md_hold = 1'b0;
            end

            if (w_md_hold) begin
                w_stall          = stall_upto(STG_EX);
                w_flush[STG_MEM] = 1'b1;
            end else if (hz.ex_redirect) begin
                // The ID instruction is wrong-path, so any load-use on it is moot.
                w_flush[STG_ID] = 1'b1;
                w_flush[STG_EX] = 1'b1;
                w_redir_take    = 1'b1;
            end else if (w_load_use) begin
                w_stall         = stall_upto(STG_ID);
                w_flush[STG_EX] = 1'b1;
                w_ld_bubble     = 1'b1;
            end else begin
                w_ld_bubble = 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Mul/div watchdog: counts MD_WAIT cycles, frozen while memory stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd <= {WD_W{1'b0}};
        end else if (w_state_nxt != MD_WAIT) begin
            r_wd <= {WD_W{1'b0}};
        end else if ((r_state == MD_WAIT) && !w_mem_wait) begin
            r_wd <= r_wd + {{(WD_W-1){1'b0}}, 1'b1};
        end else begin
            r_wd <= r_wd;
        end
    end

    assign hz.stall_if  = w_stall[STG_IF];
    assign hz.stall_id  = w_stall[STG_ID];
    assign hz.stall_ex  = w_stall[STG_EX];
    assign hz.stall_mem = w_stall[STG_MEM];
    assign hz.flush_id  = w_flush[STG_ID];
    assign hz.flush_ex  = w_flush[STG_EX];
    assign hz.flush_mem = w_flush[STG_MEM];
    assign hz.flush_wb  = w_flush[STG_WB];
    assign hz.md_start  = w_md_start;
    assign hz.md_abort  = w_md_abort;
    assign hz.trap_ack  = w_trap_ack;

`ifdef HAZARD_PERF_EN
    hazard_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ld_bubble  (w_ld_bubble),
        .i_mem_wait   (w_stall[STG_MEM]),
        .i_md_cyc     (r_state == MD_WAIT),
        .i_redirect   (w_redir_take),
        .o_ld_bubbles (hz.perf_ld_bubbles),
        .o_mem_wait   (hz.perf_mem_wait),
        .o_md_cyc     (hz.perf_md_cyc),
        .o_redirects  (hz.perf_redirects)
    );
`else
    logic w_unused_perf;
    assign w_unused_perf      = w_ld_bubble ^ w_redir_take;
    assign hz.perf_ld_bubbles = {CNT_W{1'b0}};
    assign hz.perf_mem_wait   = {CNT_W{1'b0}};
    assign hz.perf_md_cyc     = {CNT_W{1'b0}};
    assign hz.perf_redirects  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed
// by random traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int MD_MAX = 16;
    localparam int CNT_W  = 32;
`ifdef HAZARD_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    // model state
    bit   m_busy;
    int   m_waits;
    int   m_ld, m_mw, m_md, m_rd;
    // last sampled DUT flags for directed tallies
    logic last_stall_ex, last_md_start;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MD_MAX_CYC(MD_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] dut_ctl();
        return {hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem,
                hz.flush_id, hz.flush_ex, hz.flush_mem, hz.flush_wb,
                hz.md_start, hz.md_abort, hz.trap_ack};
    endfunction

    // One clock: at negedge compare DUT against the model, advance the model,
    // then return just after the next posedge so the caller can drive inputs.
    task automatic tick(input string tag);
        logic s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, f_wb, st, ab, ak;
        logic [127:0] exp_perf;
        bit held, mw, lu;
        {s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, f_wb, st, ab, ak} = 11'd0;
        @(negedge clk);
        mw = hz.mem_req && !hz.mem_ready;
        lu = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
             ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
        if (!rst_n) begin
            m_busy = 0; m_waits = 0; m_ld = 0; m_mw = 0; m_md = 0; m_rd = 0;
        end
        exp_perf = PERF_EN ? {32'(m_ld), 32'(m_mw), 32'(m_md), 32'(m_rd)} : 128'd0;
        if (rst_n) begin
            if (m_busy) m_md++;
            if (mw) begin
                {s_if, s_id, s_ex, s_mem, f_wb} = 5'b11111;
                m_mw++;
            end else if (hz.trap_req) begin
                {f_id, f_ex, f_mem, ak} = 4'b1111;
                ab = m_busy;
                m_busy = 0;
            end else begin
                held = 0;
                if (m_busy) begin
                    if (hz.md_done) m_busy = 0;
                    else if (m_waits + 1 == MD_MAX) begin ab = 1'b1; m_busy = 0; end
                    else begin m_waits++; held = 1; end
                end else if (hz.ex_is_md) begin
                    st = 1'b1; m_busy = 1; m_waits = 0; held = 1;
                end
                if (held) {s_if, s_id, s_ex, f_mem} = 4'b1111;
                else if (hz.ex_redirect) begin {f_id, f_ex} = 2'b11; m_rd++; end
                else if (lu) begin {s_if, s_id, f_ex} = 3'b111; m_ld++; end
            end
        end
        last_stall_ex = hz.stall_ex;
        last_md_start = hz.md_start;
        chk({tag, "_ctl"}, 128'(dut_ctl()),
            128'({s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, f_wb, st, ab, ak}));
        chk({tag, "_perf"}, {hz.perf_ld_bubbles, hz.perf_mem_wait, hz.perf_md_cyc, hz.perf_redirects},
            exp_perf);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
        hz.ex_rd = 5'd0; hz.ex_mem_read = 1'b0; hz.ex_is_md = 1'b0; hz.md_done = 1'b0;
        hz.mem_req = 1'b0; hz.mem_ready = 1'b0; hz.ex_redirect = 1'b0; hz.trap_req = 1'b0;
    endtask

    initial begin
        int n_st, n_start;
        n_cmp = 0; n_fail = 0;
        m_busy = 0; m_waits = 0; m_ld = 0; m_mw = 0; m_md = 0; m_rd = 0;
        rst_n = 1'b0;
        idle_inputs();
        tick("rst0");
        hz.ex_is_md = 1'b1; hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd3; hz.id_rs1 = 5'd3; hz.id_use_rs1 = 1'b1;
        tick("rst_busy_inputs");
        idle_inputs();
        rst_n = 1'b1;

        // 1: load-use on rs2
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rs2 = 5'd5; hz.id_use_rs2 = 1'b1;
        tick("t1_lu");
        idle_inputs();
        chk("t1_ld_cnt", 128'(hz.perf_ld_bubbles), PERF_EN ? 128'd1 : 128'd0);
        tick("t1_after");

        // 2: x0 destination never stalls; redirect suppresses load-use
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.id_rs2 = 5'd0; hz.id_use_rs2 = 1'b1;
        tick("t2_x0");
        hz.ex_rd = 5'd5; hz.id_rs2 = 5'd5; hz.ex_redirect = 1'b1;
        tick("t2_redir");
        idle_inputs();

        // 3: mul/div with md_done 8 cycles after start
        n_st = 0; n_start = 0;
        hz.ex_is_md = 1'b1;
        for (int c = 0; c < 9; c++) begin
            hz.md_done = (c == 8);
            tick("t3_md");
            n_st += int'(last_stall_ex);
            n_start += int'(last_md_start);
        end
        idle_inputs();
        chk("t3_stall_cycles", 128'(n_st), 128'd8);
        chk("t3_start_pulses", 128'(n_start), 128'd1);
        tick("t3_after");

        // 4: memory wait 3 cycles with a pending redirect
        hz.mem_req = 1'b1; hz.mem_ready = 1'b0; hz.ex_redirect = 1'b1;
        for (int c = 0; c < 3; c++) tick("t4_wait");
        hz.mem_ready = 1'b1;
        tick("t4_release");
        idle_inputs();

        // 5: trap during MD_WAIT
        hz.ex_is_md = 1'b1;
        for (int c = 0; c < 4; c++) tick("t5_md");
        hz.trap_req = 1'b1;
        tick("t5_trap");
        hz.trap_req = 1'b0;
        tick("t5_restart");
        hz.md_done = 1'b1;
        tick("t5_done");
        idle_inputs();

        // 6: reset in MD_WAIT
        hz.ex_is_md = 1'b1;
        for (int c = 0; c < 3; c++) tick("t6_md");
        rst_n = 1'b0;
        #1;
        chk("t6_rst_immediate", 128'(dut_ctl()), 128'd0);
        tick("t6_rst");
        rst_n = 1'b1;
        hz.ex_is_md = 1'b0;
        tick("t6_run");
        hz.ex_is_md = 1'b1;
        tick("t6_restart");
        hz.md_done = 1'b1;
        tick("t6_done");
        idle_inputs();

        // 7: watchdog expiry
        hz.ex_is_md = 1'b1;
        for (int c = 0; c <= MD_MAX; c++) tick("t7_wd");
        idle_inputs();
        tick("t7_after");

        // 8: random traffic
        for (int c = 0; c < 400; c++) begin
            hz.id_rs1      = 5'($urandom_range(0, 3));
            hz.id_rs2      = 5'($urandom_range(0, 3));
            hz.id_use_rs1  = 1'($urandom_range(0, 1));
            hz.id_use_rs2  = 1'($urandom_range(0, 1));
            hz.ex_rd       = 5'($urandom_range(0, 3));
            hz.ex_mem_read = ($urandom_range(0, 2) == 0);
            hz.ex_is_md    = ($urandom_range(0, 7) == 0);
            hz.md_done     = ($urandom_range(0, 5) == 0);
            hz.mem_req     = ($urandom_range(0, 2) == 0);
            hz.mem_ready   = ($urandom_range(0, 1) == 0);
            hz.ex_redirect = ($urandom_range(0, 4) == 0);
            hz.trap_req    = ($urandom_range(0, 15) == 0);
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
